alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Multi-cycle issue controller for the Semi-MIPS datapath: the initiator side of the ALU's `opcode`/operand/`Zero` interface. It accepts one 32-bit instruction over a valid/ready handshake, decodes it and steers register-file addresses and operand selection. It also drives the 6-bit ALU opcode, writes back the result and updates the PC, using ALU `Zero` for branches. It sits between instruction fetch and the ALU/register-file datapath.

## Interface
- `PC_STEP`, default 4: PC increment per completed instruction.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr_valid` in 1: instruction word present.
- `instr_ready` out 1: controller can accept an instruction.
- `instr` in 32: instruction word.
- `alu_opcode` out 6: opcode to ALU.
- `alu_b_sel` out 1: ALU B source, 0 = register `rt`, 1 = `imm_ext`.
- `imm_ext` out 32: sign-extended `instr[15:0]`.
- `alu_zero` in 1: ALU `Zero` flag (result == 0).
- `rf_raddr1` out 5: read port 1 address (`rs`).
- `rf_raddr2` out 5: read port 2 address (`rt`).
- `rf_waddr` out 5: write address.
- `rf_we` out 1: register write enable, one-cycle pulse.
- `pc` out 32: program counter.
- `illegal` out 1: one-cycle pulse on an undecodable instruction.
- `halted` out 1: high after a HALT instruction until reset.

## Operation
- Fields:
  - `op = instr[31:26]`, `rs = [25:21]`, `rt = [20:16]`, `rd = [15:11]`, `funct = [5:0]`.
  - The instruction is latched on the handshake and is stable until the next accept.
- Decode:
  - **R-type** (`op = 0`):
    - `funct` 1..15 → `alu_opcode = funct`, `alu_b_sel = 0`, write `rd`.
    - Any other `funct` is illegal.
  - **I-type** (`op` 18..23) → `alu_opcode = op`, `alu_b_sel = 1`, write `rt`.
  - **SLTIU** (`op = 63`) → `alu_opcode = 63`, `alu_b_sel = 1`, write `rt`.
  - **BEQ** (`op = 24`) → `alu_opcode = 2` (subtract), `alu_b_sel = 0`, no write; taken when `alu_zero = 1`.
  - **HALT** (`op = 26`) → no ALU operation, no write.
  - Any other `op` is illegal.
- FSM states: IDLE, DECODE, EXEC, WB, HALT.
  - **IDLE**:
    - `instr_ready = 1`.
    - `instr_valid & instr_ready` → latch `instr`, go to DECODE.
  - **DECODE**:
    - Drive `rf_raddr1/2` from the latched fields; they stay stable through WB.
    - Go to EXEC.
  - **EXEC**:
    - Drive `alu_opcode`, `alu_b_sel`, `imm_ext`.
    - Register `alu_zero` at the end of the cycle.
    - Go to WB.
  - **WB**:
    - Hold the ALU controls.
    - For a writing instruction: `rf_we = 1`, `rf_waddr` = destination.
    - If the destination is register 0, `rf_we` stays 0.
    - PC update: `pc ← pc + PC_STEP`. For a taken BEQ: `pc ← pc + PC_STEP + (imm_ext << 2)`, 32-bit wrap-around.
    - Illegal instruction: `illegal = 1` this cycle, no write, `pc + PC_STEP`.
    - Go to IDLE, or to HALT if the instruction was HALT.
  - **HALT**:
    - `instr_ready = 0`, `halted = 1`, PC frozen.
    - Only `rst` exits.
- Outside EXEC/WB: `alu_opcode = 0` (ALU default, result 0), `alu_b_sel = 0`.
- HALT completes like other instructions: `pc` advances by `PC_STEP` in its WB cycle, then freezes.

## Timing
- Reset values: state IDLE, `instr_ready = 1`, `pc = 0`, `rf_we = 0`, `illegal = 0`, `halted = 0`, `alu_opcode = 0`, `alu_b_sel = 0`, `rf_raddr1/2 = 0`, `rf_waddr = 0`, `imm_ext = 0`.
- Latency: accept at edge N; DECODE in cycle N+1, EXEC in N+2, WB in N+3.
  - `pc` updated at edge N+4.
  - `instr_ready` high again in cycle N+4.
  - Throughput: one instruction per 4 cycles.
- `instr_ready` is low in DECODE, EXEC, WB and HALT. `instr_valid` during those states is ignored, with no accept.
- `rst` in any state, including mid-instruction, aborts the instruction with no `rf_we` and restores the reset values on the next edge.
- `alu_zero` is sampled only at the end of EXEC; it is don't-care elsewhere.

## Test plan
- **Reset then R-type ADD:** reset, then `instr = {6'd0, rs=1, rt=2, rd=3, 5'd0, 6'd1}`. Accept at cycle 0 → `alu_opcode = 1` and `alu_b_sel = 0` in cycles 2–3; `rf_we = 1` with `rf_waddr = 3` in cycle 3; `pc = 4` after that; `instr_ready = 1` in cycle 4.
- **ADDI with negative immediate:** `op = 18`, `rt = 5`, `imm = 0xFFFE` → `imm_ext = 0xFFFFFFFE`, `alu_b_sel = 1`, `rf_we` with `rf_waddr = 5`.
- **BEQ:** `op = 24`, `imm = 3`.
  - `alu_zero = 1` in EXEC → `pc` goes 0 → 16, `alu_opcode = 2`, no `rf_we`.
  - Repeat with `alu_zero = 0` → `pc = 20`.
- **Illegal and `$zero` destination:** `op = 40` → `illegal` pulses one cycle in WB, no write, `pc + 4`. R-type `funct = 16` → illegal. ADD with `rd = 0` → `rf_we` stays 0, `pc` advances.
- **HALT:** `op = 26` → `halted = 1` and `instr_ready = 0` from cycle 4; `pc` = prior + 4, then frozen; `instr_valid` held high is not accepted. `rst` → IDLE, `pc = 0`.
- **Reset mid-instruction and busy handshake:** assert `rst` in the EXEC cycle of an ADD → no `rf_we`, `pc = 0` next cycle. Hold `instr_valid` during DECODE → no second accept until cycle 4.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle Semi-MIPS issue controller (IDLE/DECODE/EXEC/WB/HALT)
//   params : PC_STEP - pc increment per completed instruction
//   in     : clk, rst (sync, active-high), instr_valid, instr[31:0], alu_zero
//   out    : instr_ready, alu_opcode[5:0], alu_b_sel, imm_ext[31:0],
//            rf_raddr1/2[4:0], rf_waddr[4:0], rf_we, pc[31:0], illegal, halted
module alu_issue_ctrl #(
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [5:0]  alu_opcode,
  output logic        alu_b_sel,
  output logic [31:0] imm_ext,
  input  logic        alu_zero,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  output logic [4:0]  rf_waddr,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        illegal,
  output logic        halted
);
  typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, HALT} state_t;
  state_t state_q, state_d;
  logic [31:0] instr_q, instr_d, pc_q, pc_d, imm_ext_q, imm_ext_d;
  logic [5:0] alu_opcode_q, alu_opcode_d;
  logic [4:0] rf_raddr1_q, rf_raddr1_d, rf_raddr2_q, rf_raddr2_d, rf_waddr_q, rf_waddr_d;
  logic ready_q, ready_d, alu_b_sel_q, alu_b_sel_d, rf_we_q, rf_we_d;
  logic illegal_q, illegal_d, halted_q, halted_d, zero_q, zero_d;
  logic [5:0] op, funct, opc;
  logic [4:0] dest;
  logic r_ok, i_type, is_beq, is_halt, legal, wr;
  logic [31:0] imm;
  assign op      = instr_q[31:26];
  assign funct   = instr_q[5:0];
  assign r_ok    = op == 6'd0 && funct != 6'd0 && funct < 6'd16;
  assign i_type  = (op >= 6'd18 && op <= 6'd23) || op == 6'd63;
  assign is_beq  = op == 6'd24;
  assign is_halt = op == 6'd26;
  assign legal   = r_ok || i_type || is_beq || is_halt;
  assign wr      = r_ok || i_type;
  assign opc     = r_ok ? funct : i_type ? op : is_beq ? 6'd2 : 6'd0;
  assign dest    = op == 6'd0 ? instr_q[15:11] : instr_q[20:16];
  assign imm     = {{16{instr_q[15]}}, instr_q[15:0]};
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    imm_ext_d    = imm_ext_q;
    zero_d       = zero_q;
    ready_d      = ready_q;
    rf_raddr1_d  = rf_raddr1_q;
    rf_raddr2_d  = rf_raddr2_q;
    rf_waddr_d   = rf_waddr_q;
    halted_d     = halted_q;
    alu_opcode_d = 6'd0;
    alu_b_sel_d  = 1'b0;
    rf_we_d      = 1'b0;
    illegal_d    = 1'b0;
    case (state_q)
      IDLE: if (instr_valid) begin
        instr_d     = instr;
        rf_raddr1_d = instr[25:21];
        rf_raddr2_d = instr[20:16];
        ready_d     = 1'b0;
        state_d     = DECODE;
      end
      DECODE: begin
        alu_opcode_d = opc;
        alu_b_sel_d  = i_type;
        imm_ext_d    = imm;
        state_d      = EXEC;
      end
      EXEC: begin
        alu_opcode_d = opc;
        alu_b_sel_d  = i_type;
        zero_d       = alu_zero;
        rf_we_d      = wr && dest != 5'd0;
        rf_waddr_d   = dest;
        illegal_d    = !legal;
        state_d      = WB;
      end
      WB: begin
        pc_d     = pc_q + PC_STEP + ((is_beq && zero_q) ? {imm_ext_q[29:0], 2'b00} : 32'd0);
        ready_d  = !is_halt;
        halted_d = is_halt;
        state_d  = is_halt ? HALT : IDLE;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      instr_q      <= '0;
      pc_q         <= '0;
      imm_ext_q    <= '0;
      zero_q       <= 1'b0;
      ready_q      <= 1'b1;
      rf_raddr1_q  <= '0;
      rf_raddr2_q  <= '0;
      rf_waddr_q   <= '0;
      halted_q     <= 1'b0;
      alu_opcode_q <= '0;
      alu_b_sel_q  <= 1'b0;
      rf_we_q      <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      imm_ext_q    <= imm_ext_d;
      zero_q       <= zero_d;
      ready_q      <= ready_d;
      rf_raddr1_q  <= rf_raddr1_d;
      rf_raddr2_q  <= rf_raddr2_d;
      rf_waddr_q   <= rf_waddr_d;
      halted_q     <= halted_d;
      alu_opcode_q <= alu_opcode_d;
      alu_b_sel_q  <= alu_b_sel_d;
      rf_we_q      <= rf_we_d;
      illegal_q    <= illegal_d;
    end
  end
  assign instr_ready = ready_q;
  assign alu_opcode  = alu_opcode_q;
  assign alu_b_sel   = alu_b_sel_q;
  assign imm_ext     = imm_ext_q;
  assign rf_raddr1   = rf_raddr1_q;
  assign rf_raddr2   = rf_raddr2_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_we       = rf_we_q;
  assign pc          = pc_q;
  assign illegal     = illegal_q;
  assign halted      = halted_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench for alu_issue_ctrl with directed instruction vectors
module tb_alu_issue_ctrl;
  logic clk = 0, rst = 1, instr_valid = 0, alu_zero = 0;
  logic [31:0] instr = '0;
  logic instr_ready, alu_b_sel, rf_we, illegal, halted;
  logic [5:0] alu_opcode;
  logic [31:0] imm_ext, pc;
  logic [4:0] rf_raddr1, rf_raddr2, rf_waddr;
  int total = 0, bad = 0;
  typedef struct {
    logic [4:0] ra1, ra2;
    logic [5:0] opc;
    logic bsel;
    logic [31:0] imm;
    logic we;
    logic [4:0] wa;
    logic ill, hlt;
    logic [31:0] pc;
    logic abort;
  } exp_t;
  exp_t sb[$];
  alu_issue_ctrl #(.PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_opcode(alu_opcode), .alu_b_sel(alu_b_sel), .imm_ext(imm_ext),
    .alu_zero(alu_zero), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_waddr(rf_waddr), .rf_we(rf_we), .pc(pc), .illegal(illegal), .halted(halted)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic exp_t mk(input logic [4:0] ra1, ra2, input logic [5:0] opc,
                              input logic bsel, input logic [31:0] imm, input logic we,
                              input logic [4:0] wa, input logic ill, hlt,
                              input logic [31:0] pcv, input logic abort);
    exp_t e;
    e.ra1 = ra1; e.ra2 = ra2; e.opc = opc; e.bsel = bsel; e.imm = imm; e.we = we;
    e.wa = wa; e.ill = ill; e.hlt = hlt; e.pc = pcv; e.abort = abort;
    return e;
  endfunction
  task automatic issue(input logic [31:0] ins, input logic z, input exp_t e);
    int n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) chk("ready_timeout", {31'd0, instr_ready}, 32'd1);
    instr = ins;
    alu_zero = z;
    instr_valid = 1;
    sb.push_back(e);
    @(posedge clk);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst || !(instr_valid && instr_ready)) continue;
      if (sb.size() == 0) begin
        chk("spurious_accept", 32'd1, 32'd0);
        continue;
      end
      e = sb.pop_front();
      @(negedge clk);
      chk("dec_raddr1", {27'd0, rf_raddr1}, {27'd0, e.ra1});
      chk("dec_raddr2", {27'd0, rf_raddr2}, {27'd0, e.ra2});
      chk("dec_ready", {31'd0, instr_ready}, 32'd0);
      chk("dec_opcode", {26'd0, alu_opcode}, 32'd0);
      @(negedge clk);
      chk("ex_opcode", {26'd0, alu_opcode}, {26'd0, e.opc});
      chk("ex_bsel", {31'd0, alu_b_sel}, {31'd0, e.bsel});
      chk("ex_imm", imm_ext, e.imm);
      chk("ex_ready", {31'd0, instr_ready}, 32'd0);
      chk("ex_we", {31'd0, rf_we}, 32'd0);
      @(negedge clk);
      chk("wb_we", {31'd0, rf_we}, {31'd0, e.we});
      if (e.abort) begin
        @(negedge clk);
        chk("abort_pc", pc, 32'd0);
        chk("abort_ready", {31'd0, instr_ready}, 32'd1);
        continue;
      end
      if (e.we) chk("wb_waddr", {27'd0, rf_waddr}, {27'd0, e.wa});
      chk("wb_opcode", {26'd0, alu_opcode}, {26'd0, e.opc});
      chk("wb_bsel", {31'd0, alu_b_sel}, {31'd0, e.bsel});
      chk("wb_illegal", {31'd0, illegal}, {31'd0, e.ill});
      chk("wb_ready", {31'd0, instr_ready}, 32'd0);
      @(negedge clk);
      chk("done_pc", pc, e.pc);
      chk("done_ready", {31'd0, instr_ready}, {31'd0, !e.hlt});
      chk("done_halted", {31'd0, halted}, {31'd0, e.hlt});
      chk("done_we", {31'd0, rf_we}, 32'd0);
      chk("done_illegal", {31'd0, illegal}, 32'd0);
      chk("done_opcode", {26'd0, alu_opcode}, 32'd0);
    end
  end
  initial begin
    int n = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_pc", pc, 32'd0);
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_opcode", {26'd0, alu_opcode}, 32'd0);
    chk("rst_bsel", {31'd0, alu_b_sel}, 32'd0);
    chk("rst_imm", imm_ext, 32'd0);
    chk("rst_raddr", {22'd0, rf_raddr1, rf_raddr2, rf_waddr}, 32'd0);
    rst = 0;
    issue(32'h00221801, 0, mk(1, 2, 1, 0, 32'h00001801, 1, 3, 0, 0, 32'd4, 0));
    issue(32'h4805FFFE, 0, mk(0, 5, 18, 1, 32'hFFFFFFFE, 1, 5, 0, 0, 32'd8, 0));
    issue(32'h00221801, 0, mk(1, 2, 1, 0, 32'h00001801, 0, 0, 0, 0, 32'd0, 1));
    @(negedge clk);
    @(negedge clk);
    instr_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    issue(32'h60220003, 1, mk(1, 2, 2, 0, 32'h00000003, 0, 0, 0, 0, 32'd16, 0));
    issue(32'h60220003, 0, mk(1, 2, 2, 0, 32'h00000003, 0, 0, 0, 0, 32'd20, 0));
    issue(32'hA0000000, 0, mk(0, 0, 0, 0, 32'h00000000, 0, 0, 1, 0, 32'd24, 0));
    issue(32'h00221810, 0, mk(1, 2, 0, 0, 32'h00001810, 0, 0, 1, 0, 32'd28, 0));
    issue(32'h00220001, 0, mk(1, 2, 1, 0, 32'h00000001, 0, 0, 0, 0, 32'd32, 0));
    issue(32'hFC078000, 0, mk(0, 7, 63, 1, 32'hFFFF8000, 1, 7, 0, 0, 32'd36, 0));
    issue(32'h0022480F, 0, mk(1, 2, 15, 0, 32'h0000480F, 1, 9, 0, 0, 32'd40, 0));
    issue(32'h68000000, 0, mk(0, 0, 0, 0, 32'h00000000, 0, 0, 0, 1, 32'd44, 0));
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("halt_ready", {31'd0, instr_ready}, 32'd0);
      chk("halt_halted", {31'd0, halted}, 32'd1);
      chk("halt_pc", pc, 32'd44);
    end
    instr_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("post_rst_pc", pc, 32'd0);
    chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("post_rst_halted", {31'd0, halted}, 32'd0);
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
